score_display_scan: RTL and testbench

// - Parametrised successor to the fixed 4-digit score display: takes an unsigned binary score and drives
//   an N-digit multiplexed 7-segment display.
// - Converts binary to BCD sequentially (iterative double-dabble), saturates on overflow and blanks leading zeros.
// - Adds per-digit decimal points and a whole-display blink mode.
// - Sits between the game-logic score register and the board segment/anode pins.

---
 rtl/score_disp_pkg.sv | 49 ++++
 rtl/score_display_scan_bin2bcd.sv | 73 +++++++
 rtl/score_display_scan.sv | 121 ++++++++++++
 tb/tb_score_display_scan.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_disp_pkg.sv
// Shared constants and helpers for the multiplexed score display: 7-segment codes,
// the conversion FSM state type and the decimal saturation limit.
package score_disp_pkg;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] BLANK = 7'h7F;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_SHIFT,
    CONV_DONE
  } conv_state_t;

  function automatic logic [6:0] seg7_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg7_decode = SEG_0;
      4'd1:    seg7_decode = SEG_1;
      4'd2:    seg7_decode = SEG_2;
      4'd3:    seg7_decode = SEG_3;
      4'd4:    seg7_decode = SEG_4;
      4'd5:    seg7_decode = SEG_5;
      4'd6:    seg7_decode = SEG_6;
      4'd7:    seg7_decode = SEG_7;
      4'd8:    seg7_decode = SEG_8;
      4'd9:    seg7_decode = SEG_9;
      default: seg7_decode = BLANK;
    endcase
  endfunction

  // Bounded loop so it stays a clean constant function for N_DIGITS in 1..8
  function automatic int unsigned pow10(input int n);
    int unsigned r;
    r = 1;
    for (int i = 0; i < 8; i++)
      if (i < n) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/score_display_scan_bin2bcd.sv
// Iterative double-dabble: SCORE_W shift cycles, then one DONE cycle in which
// o_bcd holds the finished result.
module bin2bcd_seq
  import score_disp_pkg::*;
#(
  parameter int SCORE_W  = 10,
  parameter int N_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [SCORE_W-1:0]    i_bin,
  output logic [4*N_DIGITS-1:0] o_bcd,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int CNT_W = $clog2(SCORE_W + 1);

  conv_state_t           state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [SCORE_W-1:0]    bin_q;
  logic [4*N_DIGITS-1:0] bcd_q;
  logic [4*N_DIGITS-1:0] bcd_adj;

  always_ff @(posedge clk) begin
    if (rst) state <= CONV_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    case (state)
      CONV_IDLE:  if (i_start) state_nxt = CONV_SHIFT;
      CONV_SHIFT: begin
        o_busy = 1'b1;
        if (cnt == CNT_W'(SCORE_W - 1)) state_nxt = CONV_DONE;
      end
      CONV_DONE: begin
        o_busy    = 1'b1;
        o_done    = 1'b1;
        state_nxt = CONV_IDLE;
      end
      default: state_nxt = CONV_IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < N_DIGITS; k++)
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      bin_q <= '0;
      bcd_q <= '0;
    end else if (state == CONV_IDLE && i_start) begin
      cnt   <= '0;
      bin_q <= i_bin;
      bcd_q <= '0;
    end else if (state == CONV_SHIFT) begin
      cnt            <= cnt + 1'b1;
      {bcd_q, bin_q} <= {bcd_adj[4*N_DIGITS-2:0], bin_q, 1'b0};
    end
  end

  assign o_bcd = bcd_q;

endmodule

// File: rtl/score_display_scan.sv
// N-digit multiplexed 7-segment score display: saturating sequential BCD conversion,
// leading-zero blanking, per-digit decimal points and whole-display blink.
module score_display_scan
  import score_disp_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int SCORE_W   = 10,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 2**24,
  parameter int LZ_BLANK  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SCORE_W-1:0]  i_score,
  input  logic [N_DIGITS-1:0] i_points,
  input  logic                i_blink,
  output logic [7:0]          o_segment,
  output logic [N_DIGITS-1:0] o_segment_an,
  output logic                o_busy,
  output logic                o_ovf
);

  localparam int unsigned SAT = pow10(N_DIGITS) - 1;
  localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int BL_W  = $clog2(2 * BLINK_DIV);

  logic [SCORE_W-1:0]             last_val;
  logic                           ovf_pend;
  logic [4*N_DIGITS-1:0]          disp;
  logic [4*N_DIGITS-1:0]          conv_bcd;
  logic                           conv_busy, conv_done, conv_start;
  logic                           score_big;
  logic [SCORE_W-1:0]             conv_operand;
  logic [PS_W-1:0]                ps_cnt;
  logic [IDX_W-1:0]               idx;
  logic [BL_W-1:0]                bl_cnt;
  logic                           blink_off;
  logic [N_DIGITS-1:0][6:0]       digit_seg;
  logic                           run_zero;

  // Changes while the converter is busy are picked up by the re-compare once it is idle
  assign conv_start   = !conv_busy && (i_score != last_val);
  assign score_big    = 64'(i_score) > 64'(SAT);
  assign conv_operand = score_big ? SCORE_W'(SAT) : i_score;

  bin2bcd_seq #(
    .SCORE_W  (SCORE_W),
    .N_DIGITS (N_DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .i_start (conv_start),
    .i_bin   (conv_operand),
    .o_bcd   (conv_bcd),
    .o_busy  (conv_busy),
    .o_done  (conv_done)
  );

  assign o_busy = conv_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_val <= '0;
      ovf_pend <= 1'b0;
      disp     <= '0;
      o_ovf    <= 1'b0;
    end else begin
      if (conv_start) begin
        last_val <= i_score;
        ovf_pend <= score_big;
      end
      if (conv_done) begin
        disp  <= conv_bcd;
        o_ovf <= ovf_pend;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_cnt <= '0;
      idx    <= '0;
    end else if (ps_cnt == PS_W'(SCAN_DIV - 1)) begin
      ps_cnt <= '0;
      idx    <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      ps_cnt <= ps_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                  bl_cnt <= '0;
    else if (bl_cnt == BL_W'(2*BLINK_DIV - 1)) bl_cnt <= '0;
    else                                      bl_cnt <= bl_cnt + 1'b1;
  end

  assign blink_off = i_blink && (bl_cnt >= BL_W'(BLINK_DIV));

  // Walk from the most significant digit down, tracking whether everything above is zero
  always_comb begin
    run_zero  = 1'b1;
    digit_seg = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      run_zero = run_zero && (disp[4*k +: 4] == 4'd0);
      if (LZ_BLANK != 0 && k != 0 && run_zero) digit_seg[k] = BLANK;
      else                                     digit_seg[k] = seg7_decode(disp[4*k +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_segment    <= 8'hFF;
      o_segment_an <= '1;
    end else begin
      o_segment    <= {~i_points[idx], digit_seg[idx]};
      o_segment_an <= blink_off ? '1 : ~(N_DIGITS'(1) << idx);
    end
  end

endmodule

// File: tb/tb_score_display_scan.sv
// Scoreboard bench: stimulus queues expected display contents, a monitor pops them on
// each end of conversion and checks the scanned digits against a decimal reference model.
module tb_score_display_scan;

  localparam int SCORE_W   = 10;
  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 64;

  typedef struct packed {
    logic            scan;
    logic            ovf;
    logic [3:0][7:0] seg;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [SCORE_W-1:0] score0 = '0, score1 = '0, score2 = '0;
  logic [3:0]         pts0 = '0, pts1 = '0;
  logic [1:0]         pts2 = '0;
  logic               blink0 = 1'b0, blink_zero = 1'b0;
  logic [7:0]         seg0, seg1, seg2;
  logic [3:0]         an0, an1;
  logic [1:0]         an2;
  logic               busy0, busy1, busy2, ovf0, ovf1, ovf2;

  score_display_scan #(.N_DIGITS(4), .SCORE_W(SCORE_W), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV), .LZ_BLANK(1)) dut (
    .clk(clk), .rst(rst), .i_score(score0), .i_points(pts0), .i_blink(blink0),
    .o_segment(seg0), .o_segment_an(an0), .o_busy(busy0), .o_ovf(ovf0));

  score_display_scan #(.N_DIGITS(4), .SCORE_W(SCORE_W), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV), .LZ_BLANK(0)) dut_lz0 (
    .clk(clk), .rst(rst), .i_score(score1), .i_points(pts1), .i_blink(blink_zero),
    .o_segment(seg1), .o_segment_an(an1), .o_busy(busy1), .o_ovf(ovf1));

  score_display_scan #(.N_DIGITS(2), .SCORE_W(SCORE_W), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV), .LZ_BLANK(1)) dut_n2 (
    .clk(clk), .rst(rst), .i_score(score2), .i_points(pts2), .i_blink(blink_zero),
    .o_segment(seg2), .o_segment_an(an2), .o_busy(busy2), .o_ovf(ovf2));

  logic [7:0] seg_m [3];
  logic [3:0] an_m  [3];
  logic       busy_m[3];
  assign seg_m[0] = seg0;  assign an_m[0] = an0;           assign busy_m[0] = busy0;
  assign seg_m[1] = seg1;  assign an_m[1] = an1;           assign busy_m[1] = busy1;
  assign seg_m[2] = seg2;  assign an_m[2] = {2'b11, an2};  assign busy_m[2] = busy2;

  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  int   exp_done = 0;
  int   cyc = 0;
  int   last_fall_cyc = 0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  default: return 7'h10;
    endcase
  endfunction

  // Decimal view of the spec: saturate to 10^nd-1, digit k blank iff value < 10^k (k>0)
  function automatic logic [3:0][7:0] model_segs(input int unsigned v, input int nd, input bit lz, input logic [3:0] pts);
    int unsigned lim, p;
    logic [3:0][7:0] r;
    lim = 1;
    for (int k = 0; k < nd; k++) lim = lim * 10;
    lim = lim - 1;
    if (v > lim) v = lim;
    p = 1;
    r = '1;
    for (int k = 0; k < nd; k++) begin
      if (lz && k != 0 && v < p) r[k] = {~pts[k], 7'h7F};
      else                       r[k] = {~pts[k], ref_seg(int'((v / p) % 10))};
      p = p * 10;
    end
    return r;
  endfunction

  function automatic bit model_ovf(input int unsigned v, input int nd);
    int unsigned lim;
    lim = 1;
    for (int k = 0; k < nd; k++) lim = lim * 10;
    return v > lim - 1;
  endfunction

  // Last observation of each digit wins, so a stale first sample is overwritten
  task automatic scan_capture(input int d, input int nd, output logic [3:0][7:0] got, output logic [3:0] seen);
    got  = '1;
    seen = '0;
    repeat (2*nd*SCAN_DIV + 2) begin
      @(negedge clk);
      for (int k = 0; k < nd; k++)
        if (an_m[d] == ~(4'(1) << k)) begin
          got[k]  = seg_m[d];
          seen[k] = 1'b1;
        end
    end
  endtask

  task automatic check_digits(input string name, input int nd, input logic [3:0][7:0] got,
                              input logic [3:0] seen, input logic [3:0][7:0] req);
    for (int k = 0; k < nd; k++) begin
      checks++;
      if (!seen[k] || got[k] !== req[k]) begin
        errors++;
        $display("FAIL %s digit%0d: got %0h (seen=%0b), expected %0h", name, k, got[k], seen[k], req[k]);
      end
    end
  endtask

  task automatic push_exp(input int unsigned v, input bit scan);
    exp_t e;
    e.scan = scan;
    e.ovf  = model_ovf(v, 4);
    e.seg  = model_segs(v, 4, 1'b1, pts0);
    sb.push_back(e);
    exp_done++;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_cnt < exp_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_cnt < exp_done) begin
      errors++;
      $display("FAIL %s timeout: done=%0d, expected %0d", name, done_cnt, exp_done);
    end
  endtask

  task automatic wait_conv(input int d, input string name);
    bit saw, ok;
    saw = 0;
    ok  = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (busy_m[d]) saw = 1;
      else if (saw) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s conversion timeout: saw_busy=%0b, required 1", name, saw);
    end
  endtask

  initial begin : monitor
    int              run;
    exp_t            e;
    logic [3:0][7:0] got;
    logic [3:0]      seen;
    run = 0;
    forever begin
      @(negedge clk);
      if (rst) run = 0;
      else if (busy0) run++;
      else if (run != 0) begin
        last_fall_cyc = cyc;
        chk("busy_len", 64'(run), 64'(SCORE_W + 1));
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_conv: got conversion, expected none");
        end else begin
          e = sb.pop_front();
          chk("ovf", 64'(ovf0), 64'(e.ovf));
          if (e.scan) begin
            scan_capture(0, 4, got, seen);
            check_digits("scan", 4, got, seen, e.seg);
          end
        end
        run = 0;
        done_cnt++;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [3:0][7:0] got;
    logic [3:0]      seen;
    int unsigned     last_model, v, chg;
    int unsigned     dir_vals[5] = '{123, 1023, 0, 999, 1000};
    logic [7:0]      d0seg, d1seg;
    bit              cur, st, first;
    int              runlen, nruns, n;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_seg", 64'(seg0), 64'hFF);
    chk("rst_an", 64'(an0), 64'hF);
    chk("rst_busy", 64'(busy0), 64'h0);
    chk("rst_ovf", 64'(ovf0), 64'h0);
    rst = 1'b0;
    scan_capture(0, 4, got, seen);
    check_digits("post_rst", 4, got, seen, model_segs(0, 4, 1'b1, 4'b0000));
    last_model = 0;

    foreach (dir_vals[i]) begin
      @(posedge clk); #1;
      score0 = SCORE_W'(dir_vals[i]);
      push_exp(dir_vals[i], 1'b1);
      last_model = dir_vals[i];
      wait_done("directed");
    end

    for (int i = 0; i < 10; i++) begin
      v = $urandom_range(0, 1023);
      @(posedge clk); #1;
      pts0   = 4'($urandom);
      score0 = SCORE_W'(v);
      if (v != last_model) begin
        push_exp(v, 1'b1);
        last_model = v;
        wait_done("random");
      end else begin
        repeat (3 * SCAN_DIV * 4) @(negedge clk);
      end
    end

    // Changes while busy: 5 converts, 6 is skipped, 7 follows
    pts0 = '0;
    @(posedge clk); #1;
    score0 = 10'd5;
    push_exp(5, 1'b0);
    @(posedge clk); #1;
    score0 = 10'd6;
    @(posedge clk); #1;
    score0 = 10'd7;
    chg = cyc;
    push_exp(7, 1'b1);
    last_model = 7;
    wait_done("burst");
    chk("burst_latency_le25", 64'((last_fall_cyc - chg) <= 25), 64'h1);

    // Reset in the middle of a conversion
    @(posedge clk); #1;
    score0 = 10'd500;
    repeat (4) @(posedge clk);
    #1;
    rst    = 1'b1;
    score0 = '0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy", 64'(busy0), 64'h0);
    rst = 1'b0;
    scan_capture(0, 4, got, seen);
    check_digits("midrst_disp", 4, got, seen, model_segs(0, 4, 1'b1, 4'b0000));
    chk("midrst_ovf", 64'(ovf0), 64'h0);

    // Blink with a decimal point on digit 1
    pts0   = 4'b0010;
    blink0 = 1'b1;
    first  = 1;
    runlen = 0;
    nruns  = 0;
    st     = 0;
    d0seg  = 8'h00;
    d1seg  = 8'h00;
    repeat (400) begin
      @(negedge clk);
      cur = (an0 == 4'hF);
      if (an0 == 4'hE) d0seg = seg0;
      if (an0 == 4'hD) d1seg = seg0;
      if (runlen == 0) begin
        st     = cur;
        runlen = 1;
      end else if (cur == st) begin
        runlen++;
      end else begin
        if (!first) begin
          chk("blink_window", 64'(runlen), 64'(BLINK_DIV));
          nruns++;
        end
        first  = 0;
        st     = cur;
        runlen = 1;
      end
    end
    chk("blink_runs", 64'(nruns >= 4), 64'h1);
    chk("dp_digit1", 64'(d1seg), 64'h7F);
    chk("dp_digit0", 64'(d0seg), 64'hC0);

    n = 0;
    while (an0 == 4'hF && n < 200) begin @(negedge clk); n++; end
    while (an0 != 4'hF && n < 200) begin @(negedge clk); n++; end
    repeat (8) @(negedge clk);
    chk("blink_off_seen", 64'(an0), 64'hF);
    blink0 = 1'b0;
    @(negedge clk);
    chk("blink_release", 64'(an0 == 4'hF), 64'h0);

    // No leading-zero blanking
    @(posedge clk); #1;
    score1 = 10'd7;
    wait_conv(1, "lz0");
    scan_capture(1, 4, got, seen);
    check_digits("lz0", 4, got, seen, model_segs(7, 4, 1'b0, 4'b0000));
    chk("lz0_ovf", 64'(ovf1), 64'h0);

    // Two-digit saturation and recovery
    @(posedge clk); #1;
    score2 = 10'd1000;
    wait_conv(2, "n2_sat");
    chk("n2_ovf_set", 64'(ovf2), 64'(model_ovf(1000, 2)));
    scan_capture(2, 2, got, seen);
    check_digits("n2_sat", 2, got, seen, model_segs(1000, 2, 1'b1, 4'b0000));
    @(posedge clk); #1;
    score2 = 10'd42;
    wait_conv(2, "n2_42");
    chk("n2_ovf_clr", 64'(ovf2), 64'(model_ovf(42, 2)));
    scan_capture(2, 2, got, seen);
    check_digits("n2_42", 2, got, seen, model_segs(42, 2, 1'b1, 4'b0000));

    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
